// File: rtl/rx_lane_sync_idle.sv
// Multi-lane receive synchroniser for the byte-parallel PHY path.
// Each lane independently acquires sync on a run of commas, drops it on a
// run of code errors, and, once synced, flags idles and forwards payload.
//
// state  | meaning
// -------+----------------------------------------------------------
// UNSYNC | no alignment; waiting for the first clean comma
// COUNT  | counting consecutive clean commas toward SYNC_CNT
// SYNCED | aligned; payload/idle forwarded, counting consecutive errors
module rx_lane_sync_idle #(
  parameter int          LANES    = 4,
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter logic [7:0]  IDLE_SYM = 8'h7C,
  parameter int          SYNC_CNT = 4,
  parameter int          LOSS_CNT = 3
) (
  input  logic                 clk_4f,
  input  logic                 reset_L,
  input  logic [8*LANES-1:0]   data_in,
  input  logic [LANES-1:0]     valid_in,
  input  logic [LANES-1:0]     err_in,
  output logic [8*LANES-1:0]   data_out,
  output logic [LANES-1:0]     valid_out,
  output logic [LANES-1:0]     idle_out,
  output logic [LANES-1:0]     active,
  output logic                 all_active,
  output logic [LANES-1:0]     sync_lost
);

  localparam int CW = $clog2(SYNC_CNT + 1);
  localparam int EW = $clog2(LOSS_CNT + 1);
  localparam logic [CW:0]   SYNC_TGT = (CW+1)'(SYNC_CNT);
  localparam logic [EW:0]   LOSS_TGT = (EW+1)'(LOSS_CNT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SYNC_CNT);
  localparam logic [EW-1:0] ERR_MAX  = EW'(LOSS_CNT);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    COUNT  = 2'd1,
    SYNCED = 2'd2
  } state_e;

  // Next-state active bits of every lane, so all_active lines up with active.
  logic [LANES-1:0] active_d;
  logic             all_active_q;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] errcnt_q, errcnt_d;
    logic [CW:0]   cnt_inc;
    logic [EW:0]   errcnt_inc;
    logic [7:0]    byte_in;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          idle_q, idle_d;
    logic          active_q;
    logic          lost_q, lost_d;
    logic          sym_v, sym_err, clean_comma;

    assign byte_in     = data_in[8*n +: 8];
    assign sym_v       = valid_in[n];
    assign sym_err     = err_in[n];
    assign clean_comma = (byte_in == COMMA) && !sym_err;
    assign cnt_inc     = {1'b0, cnt_q} + (CW+1)'(1);
    assign errcnt_inc  = {1'b0, errcnt_q} + (EW+1)'(1);

    // Lane FSM next state, counters and registered-output next values.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      errcnt_d = errcnt_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      idle_d   = 1'b0;
      lost_d   = 1'b0;
      if (sym_v) begin
        unique case (state_q)
          UNSYNC: begin
            if (clean_comma) begin
              cnt_d   = CW'(1);
              state_d = (SYNC_CNT == 1) ? SYNCED : COUNT;
            end else begin
              cnt_d = '0;
            end
          end
          COUNT: begin
            if (clean_comma) begin
              if (cnt_q != CNT_MAX) cnt_d = cnt_inc[CW-1:0];
              if (cnt_inc == SYNC_TGT) state_d = SYNCED;
            end else begin
              cnt_d   = '0;
              state_d = UNSYNC;
            end
          end
          SYNCED: begin
            if (sym_err) begin
              if (errcnt_inc == LOSS_TGT) begin
                state_d  = UNSYNC;
                cnt_d    = '0;
                errcnt_d = '0;
                lost_d   = 1'b1;
              end else if (errcnt_q != ERR_MAX) begin
                errcnt_d = errcnt_inc[EW-1:0];
              end
            end else begin
              errcnt_d = '0;
              if (byte_in == IDLE_SYM) begin
                idle_d = 1'b1;
              end else if (byte_in != COMMA) begin
                data_d  = byte_in;
                valid_d = 1'b1;
              end
            end
          end
          default: begin
            state_d  = UNSYNC;
            cnt_d    = '0;
            errcnt_d = '0;
          end
        endcase
      end
    end

    assign active_d[n] = (state_d == SYNCED);

    // Lane state and output registers; cleared asynchronously on reset.
    always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
        state_q  <= UNSYNC;
        cnt_q    <= '0;
        errcnt_q <= '0;
        data_q   <= '0;
        valid_q  <= 1'b0;
        idle_q   <= 1'b0;
        active_q <= 1'b0;
        lost_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        errcnt_q <= errcnt_d;
        data_q   <= data_d;
        valid_q  <= valid_d;
        idle_q   <= idle_d;
        active_q <= active_d[n];
        lost_q   <= lost_d;
      end
    end

    assign data_out[8*n +: 8] = data_q;
    assign valid_out[n]       = valid_q;
    assign idle_out[n]        = idle_q;
    assign active[n]          = active_q;
    assign sync_lost[n]       = lost_q;
  end

  // Aggregate link-up flag, registered from next-state so it tracks active.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) all_active_q <= 1'b0;
    else          all_active_q <= &active_d;
  end

  assign all_active = all_active_q;

endmodule
